// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and sizing helpers
// shared by the multicycle ALU and its multiplier.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_BEQ = 3'b100;
   localparam logic [2:0] OP_BNE = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mul_iter.sv
// mul_iter: unsigned shift-add multiplier,
// one multiplier bit per cycle, product in acc.
module mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   localparam int CW = cnt_w(WIDTH);

   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mcand;
   logic [CW-1:0]      cnt;
   logic               run;
   logic [WIDTH:0]     sum;

   // low half of acc holds the remaining multiplier bits
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, mcand} : '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc   <= '0;
         mcand <= '0;
         cnt   <= '0;
         run   <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, b};
         mcand <= a;
         cnt   <= CW'(WIDTH);
         run   <= 1'b1;
      end else if (run) begin
         if (cnt != '0) begin
            acc <= {sum, acc[WIDTH-1:1]};
            cnt <= cnt - 1'b1;
         end else begin
            run <= 1'b0;
         end
      end
   end

   assign busy = run;
   assign done = run & (cnt == '0);
   assign prod = acc;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle execute-stage ALU behind a
// valid/ready handshake with registered results.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero
);

   state_t             state, state_d;
   logic               accept, is_mul;
   logic               load_sc, load_mul, start;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_zero;

   assign in_ready  = (state == ST_IDLE)
                    | ((state == ST_DONE) & out_ready);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid & in_ready;
   assign is_mul    = (aluop == OP_MUL) && (MUL_EN != 0);

   always_comb begin
      sc_res  = '0;
      sc_zero = 1'b0;
      unique case (aluop)
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_ADD: sc_res = a + b;
         OP_MUL: sc_res = '0;
         OP_BEQ: sc_zero = (a == b);
         OP_BNE: sc_zero = (a != b);
         OP_SUB: sc_res = a - b;
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      endcase
   end

   always_comb begin
      state_d  = state;
      load_sc  = 1'b0;
      load_mul = 1'b0;
      start    = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               if (is_mul) begin
                  start   = 1'b1;
                  state_d = ST_BUSY;
               end else begin
                  load_sc = 1'b1;
                  state_d = ST_DONE;
               end
            end else if (state == ST_DONE && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mul_done) begin
               load_mul = 1'b1;
               state_d  = ST_DONE;
            end else if (!mul_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // abort wins over any accept or completion
      if (flush) begin
         state_d  = ST_IDLE;
         load_sc  = 1'b0;
         load_mul = 1'b0;
         start    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
      end else begin
         state <= state_d;
         if (flush) begin
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
         end else if (load_sc) begin
            result    <= sc_res;
            result_hi <= '0;
            zero      <= sc_zero;
         end else if (load_mul) begin
            result    <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
            zero      <= 1'b0;
         end
      end
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .start   (start),
            .a       (a),
            .b       (b),
            .busy    (mul_busy),
            .done    (mul_done),
            .prod    (prod)
         );
      end else begin : g_nomul
         assign mul_busy = 1'b0;
         assign mul_done = 1'b0;
         assign prod     = '0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors, expected results queued
// at issue and checked by a monitor on consumption.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic [2:0]  aluop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result, result_hi;
   logic        zero;

   typedef struct packed {
      logic [31:0] r;
      logic [31:0] h;
      logic        z;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;

   alu_mc #(.WIDTH(32), .MUL_EN(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .aluop     (aluop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected got=%0h exp=none",
                     result);
         end else begin
            e = q.pop_front();
            chk("sb_result", result, e.r);
            chk("sb_result_hi", result_hi, e.h);
            chk("sb_zero", zero, e.z);
         end
      end
   end

   task automatic issue(input logic [2:0]  op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic        push,
                        input logic [31:0] er,
                        input logic [31:0] eh,
                        input logic        ez);
      int t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) chk("issue_timeout", 0, 1);
      aluop    = op;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      if (push) q.push_back('{er, eh, ez});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic mul_wait(input string nm);
      int cyc = 0;
      int bad = 0;
      while (!out_valid && cyc < 100) begin
         if (in_ready) bad++;
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, "_latency"}, cyc, 33);
      chk({nm, "_inready_busy"}, bad, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=done");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      aluop     = OP_AND;
      out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_result_hi", result_hi, 0);
      chk("rst_zero", zero, 0);
      chk("rst_in_ready", in_ready, 1);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0);
      chk("add_latency1", out_valid, 1);
      issue(OP_SUB, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 0, 0);
      issue(OP_BEQ, 32'h1234, 32'h1234, 1, 0, 0, 1);
      issue(OP_BNE, 32'h1234, 32'h1234, 1, 0, 0, 0);
      issue(OP_SLT, 32'h8000_0000, 32'h1, 1, 0, 0, 0);
      issue(OP_SLT, 32'h1, 32'h8000_0000, 1, 1, 0, 0);
      issue(OP_BNE, 32'h5, 32'h6, 1, 0, 0, 1);
      issue(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1,
            32'h2345_6789, 0, 0);
      chk("b2b_valid", out_valid, 1);
      @(posedge clk); #1;

      issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
            32'h0000_0001, 32'hFFFF_FFFE, 0);
      mul_wait("mul_max");
      @(posedge clk); #1;

      out_ready = 1'b0;
      issue(OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 1,
            32'h0F0F_00F0, 0, 0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         a = ~a;
         @(posedge clk); #1;
         if (result !== 32'h0F0F_00F0 || !out_valid || in_ready)
            seen++;
      end
      chk("bp_stable", seen, 0);
      out_ready = 1'b1;
      aluop     = OP_AND;
      a         = 32'hFF00_FF00;
      b         = 32'h0FF0_0FF0;
      in_valid  = 1'b1;
      q.push_back('{32'h0F00_0F00, 32'h0, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_nobubble_valid", out_valid, 1);
      chk("bp_nobubble_result", result, 32'h0F00_0F00);
      @(posedge clk); #1;

      issue(OP_MUL, 32'h1234, 32'h5678, 0, 0, 0, 0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_idle_valid", out_valid, 0);
      chk("flush_idle_ready", in_ready, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("flush_no_valid", seen, 0);
      issue(OP_ADD, 32'd2, 32'd2, 1, 32'd4, 0, 0);
      chk("flush_add_latency1", out_valid, 1);
      @(posedge clk); #1;

      issue(OP_MUL, 32'h55, 32'h3, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("amid_rst_valid", out_valid, 0);
      chk("amid_rst_result", result, 0);
      chk("amid_rst_result_hi", result_hi, 0);
      chk("amid_rst_ready", in_ready, 1);
      #7 reset_n = 1'b1;
      @(posedge clk); #1;
      issue(OP_MUL, 32'd7, 32'd6, 1, 32'd42, 0, 0);
      mul_wait("mul_7x6");
      repeat (5) @(posedge clk);
      #1 chk("sb_drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
